// File: rtl/echo_ranger_scan.sv
`default_nettype none
// ============================================================================
// Module   : echo_ranger_scan
// Purpose  : Round-robin trigger / echo-width front end for three ultrasonic
//            rangers; publishes registered per-sensor "object close" flags.
// Revision : 1.0 - initial release
// ============================================================================
module echo_ranger_scan #(
    parameter int TRIG_CYCLES    = 10,
    parameter int NEAR_CYCLES    = 5800,
    parameter int TIMEOUT_CYCLES = 30000,
    parameter int GAP_CYCLES     = 60000,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [2:0]       echo,
    output logic [2:0]       trig,
    output logic [2:0]       near,
    output logic             meas_valid,
    output logic [1:0]       meas_idx,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_timeout
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_TRIG      = 3'd1,
        S_WAIT_RISE = 3'd2,
        S_MEASURE   = 3'd3,
        S_HOLDOFF   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_trig_last = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_to_last   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] c_near      = CNT_W'(NEAR_CYCLES);

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         trig_q, trig_d;
    logic [2:0]         near_q, near_d;
    logic               meas_valid_q, meas_valid_d;
    logic [1:0]         meas_idx_q, meas_idx_d;
    logic [CNT_W-1:0]   meas_cnt_q, meas_cnt_d;
    logic               meas_timeout_q, meas_timeout_d;
    logic [2:0]         sync1_q, sync1_d;
    logic [2:0]         echo_s_q, echo_s_d;

    logic               w_echo_sel;
    logic [1:0]         w_idx_next;
    logic [2:0]         w_idx_onehot;
    logic [2:0]         w_next_onehot;
    logic               w_done;
    logic               w_timeout;
    logic               w_is_near;

    always_comb begin
        sync1_d  = echo;
        echo_s_d = sync1_q;
    end

    always_comb begin
        w_echo_sel = 1'b0;
        case (idx_q)
            2'd0:    w_echo_sel = echo_s_q[0];
            2'd1:    w_echo_sel = echo_s_q[1];
            2'd2:    w_echo_sel = echo_s_q[2];
            default: w_echo_sel = 1'b0;
        endcase
        w_idx_next    = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        w_idx_onehot  = 3'b001 << idx_q;
        w_next_onehot = 3'b001 << w_idx_next;
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cnt_d          = cnt_q;
        trig_d         = trig_q;
        near_d         = near_q;
        meas_valid_d   = 1'b0;
        meas_idx_d     = meas_idx_q;
        meas_cnt_d     = meas_cnt_q;
        meas_timeout_d = meas_timeout_q;
        w_done         = 1'b0;
        w_timeout      = 1'b0;
        w_is_near      = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_TRIG;
                cnt_d   = c_cnt_zero;
                trig_d  = w_idx_onehot;
            end
            S_TRIG: begin
                if (cnt_q == c_trig_last) begin
                    state_d = S_WAIT_RISE;
                    cnt_d   = c_cnt_zero;
                    trig_d  = 3'b000;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_WAIT_RISE: begin
                // The cycle on which the rise is seen already counts as width 1.
                if (w_echo_sel) begin
                    state_d = S_MEASURE;
                    cnt_d   = c_cnt_one;
                end else if (cnt_q >= c_to_last) begin
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_MEASURE: begin
                if (!w_echo_sel) begin
                    w_done = 1'b1;
                end else if (cnt_q >= c_to_last) begin
                    w_done    = 1'b1;
                    w_timeout = 1'b1;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            S_HOLDOFF: begin
                if (cnt_q == c_gap_last) begin
                    state_d = S_TRIG;
                    cnt_d   = c_cnt_zero;
                    idx_d   = w_idx_next;
                    trig_d  = w_next_onehot;
                end else begin
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = c_cnt_zero;
                trig_d  = 3'b000;
            end
        endcase

        if (w_done) begin
            w_is_near      = !w_timeout && (cnt_q < c_near);
            meas_valid_d   = 1'b1;
            meas_idx_d     = idx_q;
            meas_cnt_d     = w_timeout ? c_timeout : cnt_q;
            meas_timeout_d = w_timeout;
            near_d         = (near_q & ~w_idx_onehot) | (w_idx_onehot & {3{w_is_near}});
            state_d        = S_HOLDOFF;
            cnt_d          = c_cnt_zero;
        end

        // Disable behaves like reset for everything but the synchronisers.
        if (!ena) begin
            state_d        = S_IDLE;
            idx_d          = 2'd0;
            cnt_d          = c_cnt_zero;
            trig_d         = 3'b000;
            near_d         = 3'b000;
            meas_valid_d   = 1'b0;
            meas_idx_d     = 2'd0;
            meas_cnt_d     = c_cnt_zero;
            meas_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= 2'd0;
            cnt_q          <= c_cnt_zero;
            trig_q         <= 3'b000;
            near_q         <= 3'b000;
            meas_valid_q   <= 1'b0;
            meas_idx_q     <= 2'd0;
            meas_cnt_q     <= c_cnt_zero;
            meas_timeout_q <= 1'b0;
            sync1_q        <= 3'b000;
            echo_s_q       <= 3'b000;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            trig_q         <= trig_d;
            near_q         <= near_d;
            meas_valid_q   <= meas_valid_d;
            meas_idx_q     <= meas_idx_d;
            meas_cnt_q     <= meas_cnt_d;
            meas_timeout_q <= meas_timeout_d;
            sync1_q        <= sync1_d;
            echo_s_q       <= echo_s_d;
        end
    end

    assign trig         = trig_q;
    assign near         = near_q;
    assign meas_valid   = meas_valid_q;
    assign meas_idx     = meas_idx_q;
    assign meas_cnt     = meas_cnt_q;
    assign meas_timeout = meas_timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_echo_ranger_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_echo_ranger_scan
// Purpose  : Directed self-checking bench for echo_ranger_scan.
// Revision : 1.0 - initial release
// ============================================================================
module tb_echo_ranger_scan;

    localparam int TRIG_CYCLES    = 4;
    localparam int NEAR_CYCLES    = 20;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int GAP_CYCLES     = 8;
    localparam int CNT_W          = 16;
    localparam int WAIT_BOUND     = 400;

    logic             clk = 1'b0;
    logic             rst;
    logic             ena;
    logic [2:0]       echo;
    logic [2:0]       trig;
    logic [2:0]       near;
    logic             meas_valid;
    logic [1:0]       meas_idx;
    logic [CNT_W-1:0] meas_cnt;
    logic             meas_timeout;

    int vectors     = 0;
    int miscompares = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    echo_ranger_scan #(
        .TRIG_CYCLES   (TRIG_CYCLES),
        .NEAR_CYCLES   (NEAR_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .GAP_CYCLES    (GAP_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .echo        (echo),
        .trig        (trig),
        .near        (near),
        .meas_valid  (meas_valid),
        .meas_idx    (meas_idx),
        .meas_cnt    (meas_cnt),
        .meas_timeout(meas_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Trigger exclusivity and meas_valid spacing are watched on every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            assert ($onehot0(trig)) else begin
                miscompares++;
                $error("FAIL trig_onehot: observed %b expected at most one bit set", trig);
            end
            if (meas_valid === 1'b1) begin
                vectors++;
                assert (prev_valid !== 1'b1) else begin
                    miscompares++;
                    $error("FAIL valid_b2b: observed back-to-back meas_valid expected isolated strobe");
                end
            end
        end
        prev_valid = meas_valid;
    end

    task automatic expect_trig(input string tag, input logic [2:0] exp);
        int k = 0;
        while (trig === 3'b000 && k < WAIT_BOUND) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_seen"}, 32'(k < WAIT_BOUND), 32'd1);
        check({tag, "_value"}, 32'(trig), 32'(exp));
        k = 0;
        while (trig === exp && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_width"}, k, TRIG_CYCLES);
    endtask

    task automatic expect_meas(input string tag, input logic [1:0] e_idx, input int e_cnt,
                               input logic e_to, input logic [2:0] e_near);
        int k = 0;
        while (meas_valid !== 1'b1 && k < WAIT_BOUND) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 32'(k < WAIT_BOUND), 32'd1);
        check({tag, "_idx"}, 32'(meas_idx), 32'(e_idx));
        check({tag, "_cnt"}, 32'(meas_cnt), e_cnt);
        check({tag, "_timeout"}, 32'(meas_timeout), 32'(e_to));
        check({tag, "_near"}, 32'(near), 32'(e_near));
        @(negedge clk);
        check({tag, "_strobe_end"}, 32'(meas_valid), 32'd0);
    endtask

    task automatic pulse(input int b, input int n);
        echo[b] = 1'b1;
        repeat (n) @(negedge clk);
        echo[b] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst  = 1'b1;
        ena  = 1'b1;
        echo = 3'b000;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_near", 32'(near), 32'd0);
        check("rst_valid", 32'(meas_valid), 32'd0);
        check("rst_idx", 32'(meas_idx), 32'd0);
        check("rst_cnt", 32'(meas_cnt), 32'd0);
        check("rst_timeout", 32'(meas_timeout), 32'd0);
        rst = 1'b0;

        // Sensor 0, width 10, with crosstalk on the other echo lines.
        expect_trig("s0a", 3'b001);
        for (int k = 0; k < 10; k++) begin
            echo = {k[0], ~k[0], 1'b1};
            @(negedge clk);
        end
        echo = 3'b110;
        expect_meas("s0a", 2'd0, 10, 1'b0, 3'b001);
        echo = 3'b000;

        expect_trig("s1a", 3'b010);
        pulse(1, 19);
        expect_meas("s1a", 2'd1, 19, 1'b0, 3'b011);

        expect_trig("s2a", 3'b100);
        expect_meas("s2a_norise", 2'd2, 100, 1'b1, 3'b011);

        expect_trig("s0b", 3'b001);
        pulse(0, 5);
        expect_meas("s0b", 2'd0, 5, 1'b0, 3'b011);

        expect_trig("s1b", 3'b010);
        pulse(1, 20);
        expect_meas("s1b", 2'd1, 20, 1'b0, 3'b001);

        expect_trig("s2b", 3'b100);
        echo[2] = 1'b1;
        expect_meas("s2b_stuck", 2'd2, 100, 1'b1, 3'b001);
        echo = 3'b000;

        expect_trig("s0c", 3'b001);
        pulse(0, 19);
        expect_meas("s0c", 2'd0, 19, 1'b0, 3'b001);

        expect_trig("s1c", 3'b010);
        pulse(1, 1);
        expect_meas("s1c", 2'd1, 1, 1'b0, 3'b011);

        // Reset in the middle of sensor 2's measurement.
        expect_trig("s2c", 3'b100);
        echo[2] = 1'b1;
        repeat (6) @(negedge clk);
        check("pre_rst_near", 32'(near), 32'h3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_trig", 32'(trig), 32'd0);
        check("mid_rst_near", 32'(near), 32'd0);
        check("mid_rst_valid", 32'(meas_valid), 32'd0);
        check("mid_rst_cnt", 32'(meas_cnt), 32'd0);
        rst  = 1'b0;
        echo = 3'b000;

        expect_trig("restart_s0", 3'b001);
        pulse(0, 12);
        expect_meas("restart_s0", 2'd0, 12, 1'b0, 3'b001);

        // Dropping ena while a trigger is active.
        begin
            int k = 0;
            while (trig === 3'b000 && k < WAIT_BOUND) begin
                @(negedge clk);
                k++;
            end
            check("ena_trig_seen", 32'(k < WAIT_BOUND), 32'd1);
            check("ena_trig_value", 32'(trig), 32'h2);
        end
        ena = 1'b0;
        @(negedge clk);
        check("ena_off_trig", 32'(trig), 32'd0);
        check("ena_off_near", 32'(near), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/echo_ranger_scan.md
Name: echo_ranger_scan

Overview:
- Front end that produces the three "object close" bits consumed by the obstacle-warning state machine.
- Drives the trigger of three ultrasonic echo-ranging sensors one at a time, in round-robin order.
- Measures each sensor's echo pulse width in clock cycles and compares it to a near threshold.
- Publishes a registered near[2:0] vector, one bit per sensor, which connects directly to the warning FSM's sensor inputs.

Parameters:
- TRIG_CYCLES, 10: trigger pulse width in clk cycles.
- NEAR_CYCLES, 5800: an echo width strictly below this value means "object close".
- TIMEOUT_CYCLES, 30000: maximum cycles spent waiting for the echo rise, and separately the maximum echo width; exceeding it means no object. Must be below 2^CNT_W.
- GAP_CYCLES, 60000: idle holdoff after each measurement, before the next sensor is triggered.
- CNT_W, 16: width of the timing counter and of meas_cnt.

Ports:
- clk, input, 1: single system clock.
- rst, input, 1: synchronous, active-high reset.
- ena, input, 1: block enable.
- echo, input, 3: raw asynchronous echo lines from sensors 0..2.
- trig, output, 3: trigger lines to sensors 0..2; at most one bit high at any time.
- near, output, 3: registered "object close" flags, bit i for sensor i.
- meas_valid, output, 1: one-cycle strobe when a measurement completes.
- meas_idx, output, 2: index of the sensor just measured; valid with meas_valid.
- meas_cnt, output, CNT_W: measured echo width; equals TIMEOUT_CYCLES on timeout.
- meas_timeout, output, 1: high with meas_valid when the measurement timed out.

Behaviour:
- Reset (rst=1 at a clk edge), which overrides ena:
  - State goes to IDLE; idx=0; counter=0.
  - trig=0, near=0, meas_valid=0, meas_idx=0, meas_cnt=0, meas_timeout=0.
  - Reset asserted mid-operation aborts the measurement; near is not updated.
- Echo synchronisation:
  - Each echo bit passes through a 2-flop synchroniser, giving echo_s; this adds 2 cycles of latency.
  - Only echo_s[idx] is observed; the other two echo lines are ignored.
- ena=0 (and rst=0): same effect as reset, except the synchronisers keep running.
- States:
  - IDLE: if ena=1, go to TRIG on the next cycle with counter=0.
  - TRIG:
    - trig[idx]=1 (registered), all other trig bits 0.
    - Stays exactly TRIG_CYCLES cycles, then trig=0, counter=0, go to WAIT_RISE.
  - WAIT_RISE:
    - counter increments every cycle.
    - echo_s[idx]=1 (including on the first cycle) → go to MEASURE with counter=1.
    - counter reaches TIMEOUT_CYCLES → timeout completion.
  - MEASURE:
    - counter increments while echo_s[idx]=1.
    - echo_s[idx]=0 → normal completion with width=counter.
    - counter reaches TIMEOUT_CYCLES while echo is still high → timeout completion. A stuck-high echo therefore always times out.
  - Completion (a single cycle, registered outputs):
    - meas_valid=1, meas_idx=idx, meas_cnt=width (or TIMEOUT_CYCLES on timeout), meas_timeout=timeout.
    - near[idx] = (!timeout && width < NEAR_CYCLES); the other near bits hold their value.
    - Go to HOLDOFF with counter=0.
  - HOLDOFF:
    - Wait GAP_CYCLES cycles.
    - Then idx advances 0→1→2→0 (wrap from 2 to 0) and the FSM goes to TRIG.
- meas_valid is high for exactly one cycle per measurement; it never occurs back-to-back.
- Width boundary: width==NEAR_CYCLES−1 → near=1; width==NEAR_CYCLES → near=0.
- The counter never wraps: the timeout bounds it.

Test Plan:
All scenarios use TRIG_CYCLES=4, NEAR_CYCLES=20, TIMEOUT_CYCLES=100, GAP_CYCLES=8.
1. Release rst with ena=1 → trig=3'b001 for exactly 4 cycles; then trig=3'b010, then 3'b100, then wraps back to 3'b001; never two bits high at once.
2. Sensor 0 echo pulse 10 cycles wide → meas_valid pulses with meas_idx=0, meas_cnt=10, meas_timeout=0, near=3'b001.
3. Sensor 1 echo pulses of 19 and then 20 cycles on consecutive scans → near[1]=1 after the first scan, near[1]=0 after the second (threshold boundary).
4. Sensor 2 echo never rises; separately, echo held stuck high → meas_cnt=100, meas_timeout=1, near[2]=0 in both cases, and the scan continues to sensor 0.
5. Assert rst (or drop ena) during MEASURE with near=3'b011 → next cycle trig=0 and near=0; after release the scan restarts at sensor 0.
6. Echo toggles on non-selected sensors during sensor 0's measurement → no effect on meas_cnt or near.
